// File: rtl/gray_cnt_pkg.sv
// Shared definitions for the Gray-code SR flip-flop counter: SR cell drive
// encoding and binary/Gray conversion helpers sized for the widest counter.
package gray_cnt_pkg;

    localparam int unsigned GRAY_MAX_W = 16;

    // Cell drive encoding, packed as {S, R}
    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_RST  = 2'b01,
        SR_SET  = 2'b10,
        SR_ILL  = 2'b11
    } sr_code_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Narrower counters zero-extend, so their decoded low bits stay exact
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_srff_cell.sv
// Clocked SR flip-flop with synchronous active-high reset; S=R=1 holds.
module sr_ff_cell
    import gray_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            case (sr_code_t'({S, R}))
                SR_SET:  Q <= 1'b1;
                SR_RST:  Q <= 1'b0;
                default: Q <= Q;
            endcase
        end
    end

    assign Qb = ~Q;

endmodule

// File: rtl/gray_counter_srff.sv
// W-bit Gray-code up/down counter with one SR flip-flop cell per bit.
// Define GRAY_CNT_SR_CHECK_EN to add the sticky sr_err integrity flag.
module gray_counter_srff
    import gray_cnt_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter bit          WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q_gray,
    output logic [W-1:0] q_bin,
    output logic         tc
`ifdef GRAY_CNT_SR_CHECK_EN
    ,
    output logic         sr_err
`endif
);

    logic [W-1:0] g;
    logic [W-1:0] qb;
    logic [W-1:0] bn;
    logic [W-1:0] gn;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         at_max;
    logic         at_min;

    for (genvar i = 0; i < W; i++) begin : g_cell
        sr_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .S   (s[i]),
            .R   (r[i]),
            .Q   (g[i]),
            .Qb  (qb[i])
        );
    end

    assign q_gray = g;
    assign q_bin  = W'(gray2bin(GRAY_MAX_W'(g)));
    assign at_max = &q_bin;
    assign at_min = ~|q_bin;
    assign tc     = en & ~load & (up ? at_max : at_min);

    always_comb begin
        bn = q_bin;
        if (load) begin
            bn = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max || WRAP) bn = q_bin + W'(1);
            end else begin
                if (!at_min || WRAP) bn = q_bin - W'(1);
            end
        end
    end

    assign gn = W'(bin2gray(GRAY_MAX_W'(bn)));

    // Qb stands in for ~Q, so each cell is driven only on the bits that move
    always_comb begin
        s = '0;
        r = '1;
        if (!rst) begin
            s = qb & gn;
            r = g & ~gn;
        end
    end

`ifdef GRAY_CNT_SR_CHECK_EN
    logic [W-1:0] diff;
    logic         multi_flip;

    assign diff       = g ^ gn;
    assign multi_flip = |(diff & (diff - W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_err <= 1'b0;
        end else if ((|(s & r)) || (en && !load && multi_flip)) begin
            sr_err <= 1'b1;
        end
    end
`endif

endmodule
